// File: rtl/rf_writeback.sv
// Write-back sequencer for the integer register file: merges ALU and buffered LSU results onto
// the single write port and keeps a per-register pending scoreboard for hazard detection.
module rf_writeback #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  input  logic [ADDR_WIDTH-1:0] chk_rd,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic                  hazard_rd,
  output logic                  busy
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;
  localparam int unsigned IdxW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW    = IdxW + 1;
  localparam int unsigned EntW    = ADDR_WIDTH + DATA_WIDTH;

  // LSU result FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic            fifo_empty, fifo_full, push, pop;
  logic [EntW-1:0] fifo_head;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]) && (wptr_q[IdxW] != rptr_q[IdxW]);
  assign lsu_ready  = !fifo_full && !rst;
  assign push       = lsu_valid && lsu_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign fifo_head  = mem_q[rptr_q[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[IdxW-1:0]] <= {lsu_rd, lsu_data};
  end

  // ALU has strict priority over the buffered LSU results.
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!fifo_empty) begin
      sel_valid          = 1'b1;
      {sel_rd, sel_data} = fifo_head;
    end
  end

  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_rd_q;
  logic [DATA_WIDTH-1:0] rf_data_q;

  // x0 results are consumed but never enable a write; idle cycles hold index and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      rf_wen_q <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        rf_rd_q   <= sel_rd;
        rf_data_q <= sel_data;
      end
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_dataD = rf_data_q;

  // Scoreboard: a retiring write clears its bit, a new issue to the same index wins.
  logic [NumRegs-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (rf_wen_q) pend_d[rf_rd_q] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign hazard1   = !rst && pend_q[chk_rs1];
  assign hazard2   = !rst && pend_q[chk_rs2];
  assign hazard_rd = !rst && pend_q[chk_rd];
  assign busy      = !rst && (!fifo_empty || rf_wen_q || (|pend_q));

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed vector table, hand-written corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_rf_writeback;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_dataD;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        hazard1, hazard2, hazard_rd, busy;

  always #5 clk = ~clk;

  rf_writeback #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .rf_wen     (rf_wen),
    .rf_rd      (rf_rd),
    .rf_dataD   (rf_dataD),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .hazard_rd  (hazard_rd),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set as a bit vector, LSU buffer as a queue.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  bit [31:0]   m_pend;
  ent_t        m_fifo[$];
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_pushed;

  task automatic model_update();
    bit          sv;
    ent_t        e;
    logic [4:0]  srd;
    logic [31:0] sd;
    m_pushed = 1'b0;
    if (rst) begin
      m_pend = '0;
      m_fifo.delete();
      m_wen  = 1'b0;
      m_rd   = '0;
      m_data = '0;
    end else begin
      m_pushed = lsu_valid && (m_fifo.size() < Depth);
      if (m_wen) m_pend[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      sv = 1'b0;
      srd = '0;
      sd = '0;
      if (alu_valid) begin
        sv = 1'b1; srd = alu_rd; sd = alu_data;
      end else if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        sv = 1'b1; srd = e.rd; sd = e.d;
      end
      if (m_pushed) m_fifo.push_back('{rd: lsu_rd, d: lsu_data});
      if (sv) begin
        m_wen = (srd != 0); m_rd = srd; m_data = sd;
      end else begin
        m_wen = 1'b0;
      end
    end
  endtask

  // Called with inputs already driven, shortly after a rising edge (or at time 0).
  task automatic step();
    #1;
    chk("lsu_ready", lsu_ready, 32'(!rst && m_fifo.size() < Depth));
    chk("hazard1", hazard1, 32'(!rst && m_pend[chk_rs1]));
    chk("hazard2", hazard2, 32'(!rst && m_pend[chk_rs2]));
    chk("hazard_rd", hazard_rd, 32'(!rst && m_pend[chk_rd]));
    chk("busy", busy, 32'(!rst && (m_fifo.size() != 0 || m_wen || m_pend != 0)));
    if (issue_valid && !rst && chk_rd == issue_rd) chk("issue_rule", hazard_rd, 0);
    model_update();
    @(posedge clk);
    #1;
    chk("rf_wen", rf_wen, 32'(m_wen));
    chk("rf_rd", rf_rd, 32'(m_rd));
    chk("rf_dataD", rf_dataD, m_data);
  endtask

  task automatic idle();
    rst = 0; issue_valid = 0; issue_rd = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  typedef struct {
    logic rst; logic iv; logic [4:0] ird; logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld; logic [4:0] c1; logic [4:0] c2; logic [4:0] crd;
    logic e_ready; logic e_h1; logic e_h2; logic e_hrd; logic e_busy;
    logic e_wen; logic [4:0] e_rd; logic [31:0] e_data;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int npush;
    bit acc;

    tbl[0]  = '{1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 32'hAA, 1'b1, 5'd2, 32'hBB, 5'd3, 5'd4, 5'd3,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd5,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1234};
    tbl[9]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1234};
    tbl[10] = '{1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd7,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1234};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77};
    // New issue of x7 on the same edge its write retires: bit must stay set.
    tbl[12] = '{1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h77};
    tbl[13] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h77};
    tbl[14] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h78};
    tbl[15] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h78};
    tbl[16] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h78};

    m_pend = '0; m_wen = 1'b0; m_rd = '0; m_data = '0;
    idle();
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      chk_rs1 = tbl[i].c1; chk_rs2 = tbl[i].c2; chk_rd = tbl[i].crd;
      #1;
      chk("tbl_lsu_ready", lsu_ready, 32'(tbl[i].e_ready));
      chk("tbl_hazard1", hazard1, 32'(tbl[i].e_h1));
      chk("tbl_hazard2", hazard2, 32'(tbl[i].e_h2));
      chk("tbl_hazard_rd", hazard_rd, 32'(tbl[i].e_hrd));
      chk("tbl_busy", busy, 32'(tbl[i].e_busy));
      step();
      chk("tbl_rf_wen", rf_wen, 32'(tbl[i].e_wen));
      chk("tbl_rf_rd", rf_rd, 32'(tbl[i].e_rd));
      chk("tbl_rf_dataD", rf_dataD, tbl[i].e_data);
    end

    // ALU burst starves the LSU buffer, which then drains x1..x4 back to back.
    idle();
    npush = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_rd = 5'(20 + c); alu_data = 32'(100 + c);
      lsu_valid = (npush < 4); lsu_rd = 5'(npush + 1); lsu_data = 32'h1000 + 32'(npush);
      if (c == 4) chk("burst_ready_full", lsu_ready, 0);
      acc = lsu_valid && lsu_ready;
      step();
      if (acc) npush++;
      chk("burst_wen", rf_wen, 1);
      chk("burst_rd", rf_rd, 32'(20 + c));
    end
    chk("burst_push_count", npush, 4);
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_wen", rf_wen, 1);
      chk("drain_rd", rf_rd, 32'(k + 1));
      chk("drain_data", rf_dataD, 32'h1000 + 32'(k));
    end
    step();
    chk("drain_done_wen", rf_wen, 0);

    // Reset with 3 buffered entries and x3/x9 pending.
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
      lsu_valid = 1; lsu_rd = 5'(10 + k); lsu_data = 32'h2000 + 32'(k);
      issue_valid = (k < 2); issue_rd = (k == 0) ? 5'd3 : 5'd9; chk_rd = issue_rd;
      step();
    end
    idle();
    chk_rs1 = 3; chk_rs2 = 9;
    chk("pre_reset_busy", busy, 1);
    rst = 1;
    step();
    rst = 0;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_h1", hazard1, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_reset_no_wen", rf_wen, 0);
    end

    // Randomized traffic; issue only to registers the model says are free.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      alu_valid = ($urandom_range(0, 2) == 0); alu_rd = 5'($urandom); alu_data = $urandom;
      lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom); lsu_data = $urandom;
      issue_rd = 5'($urandom);
      issue_valid = ($urandom_range(0, 1) == 1) && !m_pend[issue_rd];
      chk_rd = issue_rd; chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
